// File: rtl/tt_check_pkg.sv
// Shared types and default sizing for the on-chip truth-table checker.
package tt_check_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int N_IN_DEFAULT = 3;
    localparam int N_VEC        = 1 << N_IN_DEFAULT;

    function automatic int nVec(input int nIn);
        return 1 << nIn;
    endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Settle counter: counts while enabled, flags the last settle cycle.
module tt_settle_timer #(
    parameter int SETTLE_CYC = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_terminal
);

    localparam int W = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC + 1);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_terminal) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_terminal = (r_count == W'(SETTLE_CYC - 1));

endmodule

// File: rtl/truth_table_checker.sv
// BIST checker: sweeps every input vector of a small combinational unit and
// compares the captured truth table against the expected one.
module truth_table_checker
    import tt_check_pkg::*;
#(
    parameter int                     N_IN       = N_IN_DEFAULT,
    parameter logic [(1<<N_IN)-1:0]   EXPECTED   = 8'hE8,
    parameter int                     SETTLE_CYC = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    output logic [N_IN-1:0]       o_stim,
    input  logic                  i_resp,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_pass,
    output logic [(1<<N_IN)-1:0]  o_captured,
    output logic [N_IN-1:0]       o_fail_idx,
    output logic [N_IN:0]         o_fail_cnt
);

    localparam int NV = nVec(N_IN);

    state_t              r_state;
    logic [N_IN-1:0]     r_vec;
    logic                r_busy;
    logic                r_done;
    logic                r_pass;
    logic [NV-1:0]       r_captured;
    logic [N_IN-1:0]     r_failIdx;
    logic [N_IN:0]       r_failCnt;

    logic                w_settleDone;
    logic                w_mismatch;
    logic [N_IN:0]       w_failCntNext;
    logic                w_lastVec;

    tt_settle_timer #(
        .SETTLE_CYC (SETTLE_CYC)
    ) u_timer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clear    (r_state != ST_SETTLE),
        .i_enable   (r_state == ST_SETTLE),
        .o_terminal (w_settleDone)
    );

    assign w_mismatch    = (i_resp != EXPECTED[r_vec]);
    assign w_failCntNext = r_failCnt + {{N_IN{1'b0}}, w_mismatch};
    assign w_lastVec     = (r_vec == N_IN'(NV - 1));

    // The vector counter doubles as stim: it is 0 in IDLE and held in DONE.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_vec      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_captured <= '0;
            r_failIdx  <= '0;
            r_failCnt  <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        r_state    <= ST_SETTLE;
                        r_vec      <= '0;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_pass     <= 1'b0;
                        r_captured <= '0;
                        r_failIdx  <= '0;
                        r_failCnt  <= '0;
                    end
                end
                ST_SETTLE: begin
                    if (w_settleDone) begin
                        r_state <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    r_captured[r_vec] <= i_resp;
                    r_failCnt         <= w_failCntNext;
                    if (w_mismatch && (r_failCnt == '0)) begin
                        r_failIdx <= r_vec;
                    end
                    if (w_lastVec) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_failCntNext == '0);
                    end else begin
                        r_state <= ST_SETTLE;
                        r_vec   <= r_vec + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_stim     = r_vec;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_pass     = r_pass;
    assign o_captured = r_captured;
    assign o_fail_idx = r_failIdx;
    assign o_fail_cnt = r_failCnt;

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed bench for truth_table_checker driving a majority-gate model with
// injectable faults; sweep results are checked through a scoreboard queue.
module tb_truth_table_checker;

    typedef struct packed {
        logic [7:0] captured;
        logic       passFlag;
        logic [2:0] failIdx;
        logic [3:0] failCnt;
    } result_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic [2:0] stim;
    logic       resp;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] captured;
    logic [2:0] failIdx;
    logic [3:0] failCnt;

    int      faultMode;
    int      compareCount;
    int      mismatchCount;
    result_t scoreboard[$];

    truth_table_checker #(
        .N_IN       (3),
        .EXPECTED   (8'hE8),
        .SETTLE_CYC (2)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .o_stim     (stim),
        .i_resp     (resp),
        .o_busy     (busy),
        .o_done     (done),
        .o_pass     (pass),
        .o_captured (captured),
        .o_fail_idx (failIdx),
        .o_fail_cnt (failCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic modelResp(input int mode, input logic [2:0] v);
        logic maj;
        maj = (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
        case (mode)
            1:       return ((v == 3'd3) || (v == 3'd6)) ? ~maj : maj;
            2:       return 1'b0;
            default: return maj;
        endcase
    endfunction

    assign resp = modelResp(faultMode, stim);

    function automatic result_t expectedResult(input int mode);
        result_t    r;
        logic [7:0] golden;
        logic       bitVal;
        golden = 8'hE8;
        r = '0;
        for (int v = 0; v < 8; v++) begin
            bitVal = modelResp(mode, 3'(v));
            r.captured[v] = bitVal;
            if (bitVal != golden[v]) begin
                if (r.failCnt == 0) r.failIdx = 3'(v);
                r.failCnt = r.failCnt + 4'd1;
            end
        end
        r.passFlag = (r.failCnt == 0);
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        assert (observed === expected)
        else begin
            mismatchCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".stim"},     32'(stim),     32'd0);
        checkOutput({tag, ".busy"},     32'(busy),     32'd0);
        checkOutput({tag, ".done"},     32'(done),     32'd0);
        checkOutput({tag, ".pass"},     32'(pass),     32'd0);
        checkOutput({tag, ".captured"}, 32'(captured), 32'd0);
        checkOutput({tag, ".failIdx"},  32'(failIdx),  32'd0);
        checkOutput({tag, ".failCnt"},  32'(failCnt),  32'd0);
    endtask

    // Starts a sweep, waits for done within a bounded budget, then pops and compares.
    task automatic applyStimulus(input int mode, input bit checkStim, input bit pulseBusy);
        int      cycles;
        result_t exp;
        faultMode = mode;
        scoreboard.push_back(expectedResult(mode));
        start = 1'b1;
        tick();
        start = 1'b0;
        cycles = 0;
        checkOutput("start.busy",     32'(busy),     32'd1);
        checkOutput("start.done",     32'(done),     32'd0);
        checkOutput("start.captured", 32'(captured), 32'd0);
        checkOutput("start.failCnt",  32'(failCnt),  32'd0);
        checkOutput("start.stim",     32'(stim),     32'd0);
        while (!done && cycles < 200) begin
            start = (pulseBusy && (cycles == 4 || cycles == 11)) ? 1'b1 : 1'b0;
            tick();
            cycles++;
            if (checkStim && !done)
                checkOutput($sformatf("stim.c%0d", cycles), 32'(stim), 32'(cycles / 3));
        end
        start = 1'b0;
        checkOutput("doneCycle", 32'(cycles), 32'd24);
        checkOutput("done.busy", 32'(busy),   32'd0);
        if (scoreboard.size() == 0) begin
            checkOutput("scoreboardEmpty", 32'd0, 32'd1);
        end else begin
            exp = scoreboard.pop_front();
            checkOutput("captured", 32'(captured), 32'(exp.captured));
            checkOutput("pass",     32'(pass),     32'(exp.passFlag));
            checkOutput("failIdx",  32'(failIdx),  32'(exp.failIdx));
            checkOutput("failCnt",  32'(failCnt),  32'(exp.failCnt));
        end
        tick();
        checkOutput("hold.done", 32'(done), 32'd1);
        checkOutput("hold.stim", 32'(stim), 32'd7);
    endtask

    initial begin
        compareCount  = 0;
        mismatchCount = 0;
        faultMode     = 0;
        start         = 1'b0;
        rst           = 1'b1;
        #12;
        checkAllZero("reset");
        @(negedge clk);
        rst = 1'b0;
        tick();
        checkAllZero("idle");

        $display("[TB] sweep with healthy majority gate");
        applyStimulus(0, 1'b0, 1'b0);

        $display("[TB] sweep with vectors 3 and 6 inverted, restarted from DONE");
        applyStimulus(1, 1'b0, 1'b0);

        $display("[TB] sweep with resp stuck at 0, stim sequence checked");
        applyStimulus(2, 1'b1, 1'b0);

        $display("[TB] reset mid-sweep");
        faultMode = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        checkOutput("preReset.busy", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkAllZero("midReset");
        @(negedge clk);
        rst = 1'b0;
        tick();
        applyStimulus(0, 1'b0, 1'b0);

        $display("[TB] start pulses while busy are ignored");
        applyStimulus(1, 1'b0, 1'b1);

        $display("[TB] repeat sweep from DONE matches previous result");
        applyStimulus(1, 1'b0, 1'b0);

        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
